cnn_axi_mem_slave: RTL

AXI4 burst slave that terminates the accelerator's AXI master port in place of DDR. Read and write channels are handled independently, and both are backed by a word-addressed synchronous memory. It is used for simulation and for on-chip BRAM test builds. It serves the DMA's data, weight and result transfers with single-beat-per-cycle throughput and reports protocol and address errors through `rresp`/`bresp`.

---
 rtl/cnn_axi_mem_slave_if.sv | 75 +++++++
 rtl/cnn_axi_mem_slave.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_axi_mem_slave_if.sv
// rtl/cnn_axi_mem_slave_if.sv - AXI4 bus bundle between the accelerator master and the memory slave
interface cnn_axi_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
);
  // write address channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  // write data channel
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // write response channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // read address channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]    arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  // read data channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cnn_axi_mem_slave.sv
// rtl/cnn_axi_mem_slave.sv - AXI4 burst slave backed by a word-addressed synchronous memory
module cnn_axi_mem_slave #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 64,
  parameter int              LEN_W     = 8,
  parameter int              ID_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int              MEM_AW    = 14
) (
  input  logic                 clk,
  input  logic                 rstn,
  cnn_axi_mem_slave_if.slave   bus
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  // word index width plus one carry bit so start word + beat never wraps
  localparam int WW = ADDR_W - OB + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  // word offset from BASE_ADDR; low byte-lane bits are dropped
  function automatic logic [WW-1:0] start_word(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return {1'b0, off[ADDR_W-1:OB]};
  endfunction

  // ---------------- write side ----------------
  w_state_t          w_state;
  logic [WW-1:0]     w_word;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_cnt;
  logic              w_base_ok;
  logic              w_err;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [ID_W-1:0]   bid_q;

  logic [WW-1:0]     w_beat_word;
  logic              w_in_range;
  logic              w_at_len;
  logic              w_fire;
  logic              w_beat_err;

  // current write beat address, range and protocol checks
  always_comb begin
    w_beat_word = w_word + WW'(w_cnt);
    w_in_range  = w_base_ok && (w_beat_word[WW-1:MEM_AW] == '0);
    w_at_len    = (w_cnt == w_len);
    w_fire      = wready_q && bus.wvalid;
    w_beat_err  = !w_in_range || (bus.wlast != w_at_len);
  end

  // byte-enabled memory write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (w_fire && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wstrb[b]) mem[w_beat_word[MEM_AW-1:0]][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
    end
  end

  // write FSM: accept AW, absorb W beats until wlast or len, then present B
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state   <= W_IDLE;
      w_word    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_base_ok <= 1'b0;
      w_err     <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.awvalid) begin
            bid_q     <= bus.awid;
            w_word    <= start_word(bus.awaddr);
            w_base_ok <= (bus.awaddr >= BASE_ADDR);
            w_len     <= bus.awlen;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.wvalid) begin
            w_err <= w_err || w_beat_err;
            // an early wlast or a missing one both terminate the burst here
            if (bus.wlast || w_at_len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
              w_state  <= W_RESP;
            end else begin
              w_cnt <= w_cnt + LEN_W'(1);
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;

  // ---------------- read side ----------------
  r_state_t          r_state;
  logic [WW-1:0]     r_word;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_base_ok;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [1:0]        rresp_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [LEN_W-1:0]  r_sel_beat;
  logic [WW-1:0]     r_beat_word;
  logic              r_in_range;
  logic              r_sel_last;
  logic [DATA_W-1:0] r_mem_data;

  // beat to fetch next: beat 0 in R_FETCH, the following beat while in R_DATA
  always_comb begin
    r_sel_beat  = (r_state == R_DATA) ? r_cnt + LEN_W'(1) : r_cnt;
    r_beat_word = r_word + WW'(r_sel_beat);
    r_in_range  = r_base_ok && (r_beat_word[WW-1:MEM_AW] == '0);
    r_sel_last  = (r_sel_beat == r_len);
    r_mem_data  = mem[r_beat_word[MEM_AW-1:0]];
  end

  // read FSM: the output register is loaded only on fetch or handshake, so stalls hold it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= R_IDLE;
      r_word    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_base_ok <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.arvalid) begin
            rid_q     <= bus.arid;
            r_word    <= start_word(bus.araddr);
            r_base_ok <= (bus.araddr >= BASE_ADDR);
            r_len     <= bus.arlen;
            r_cnt     <= '0;
            arready_q <= 1'b0;
            r_state   <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid_q <= 1'b1;
          rdata_q  <= r_in_range ? r_mem_data : '0;
          rresp_q  <= r_in_range ? 2'b00 : 2'b10;
          rlast_q  <= r_sel_last;
          r_state  <= R_DATA;
        end
        R_DATA: begin
          if (bus.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + LEN_W'(1);
              rdata_q <= r_in_range ? r_mem_data : '0;
              rresp_q <= r_in_range ? 2'b00 : 2'b10;
              rlast_q <= r_sel_last;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;

  // attributes carried on the bus that this slave deliberately ignores
  logic unused_attrs;
  assign unused_attrs = ^{bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot,
                          bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.wid};
endmodule
